// File: rtl/lcm_from_gcd.sv
// LCM stage downstream of the GCD block: lcm = (a / gcd) * b.
// The stage runs a restoring divide, then a shift-add multiply, and pulses done with the result.
module lcm_from_gcd #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 gcd_done,
   input  logic [WIDTH-1:0]     gcd_in,
   output logic                 done,
   output logic [2*WIDTH-1:0]   lcm,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_GCD,
      ST_DIV,
      ST_MUL,
      ST_DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   g_r;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   rem;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;

   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_next;
   logic [2*WIDTH-1:0] acc_next;

   // The shifted remainder is kept one bit wider so the compare never loses a carry.
   always_comb begin
      rem_shift = {rem, a_r[cnt]};
      rem_diff  = rem_shift - {1'b0, g_r};
      rem_ge    = (rem_shift >= {1'b0, g_r});
      rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      acc_next  = {acc[2*WIDTH-2:0], 1'b0} + (q[cnt] ? {{WIDTH{1'b0}}, b_r} : {(2*WIDTH){1'b0}});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         a_r   <= '0;
         b_r   <= '0;
         g_r   <= '0;
         q     <= '0;
         rem   <= '0;
         cnt   <= '0;
         acc   <= '0;
         lcm   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  busy  <= 1'b1;
                  state <= ST_WAIT_GCD;
               end
            end
            ST_WAIT_GCD: begin
               if (gcd_done) begin
                  g_r <= gcd_in;
                  if (a_r == '0 || b_r == '0 || gcd_in == '0) begin
                     lcm   <= '0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     q     <= '0;
                     rem   <= '0;
                     acc   <= '0;
                     cnt   <= CNT_TOP;
                     state <= ST_DIV;
                  end
               end
            end
            // Quotient bits enter at the LSB, so after WIDTH steps q[cnt] walks MSB first in MUL.
            ST_DIV: begin
               rem <= rem_next;
               q   <= {q[WIDTH-2:0], rem_ge};
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  cnt   <= CNT_TOP;
                  state <= ST_MUL;
               end
            end
            ST_MUL: begin
               acc <= acc_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  lcm   <= acc_next;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Directed bench for lcm_from_gcd: each run's expected lcm is queued and popped on its done pulse.
module tb_lcm_from_gcd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        gcd_done = 1'b0;
   logic [15:0] gcd_in = '0;
   logic        done;
   logic [31:0] lcm;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int done_count = 0;
   logic [31:0] exp_q[$];

   lcm_from_gcd #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .gcd_done(gcd_done), .gcd_in(gcd_in), .done(done), .lcm(lcm), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_count <= done_count + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One full transaction; intrude pulses a second start mid-DIV that must be ignored.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic [15:0] tg, input int delay, input logic [31:0] expv,
                         input int exp_lat, input bit intrude);
      int k;
      logic [31:0] popped;
      exp_q.push_back(expv);
      start = 1'b1; a = ta; b = tbv;
      @(posedge clk); #1;
      start = 1'b0; a = 16'd12; b = 16'd99;
      repeat (delay) begin @(posedge clk); #1; end
      gcd_done = 1'b1; gcd_in = tg;
      @(posedge clk); #1;
      gcd_done = 1'b0; gcd_in = 16'hdead;
      k = 0;
      while (k < 60) begin
         @(negedge clk);
         k++;
         if (done) break;
         if (intrude && k == 5) begin start = 1'b1; a = 16'd3; b = 16'd15; end
         if (intrude && k == 6) start = 1'b0;
      end
      check({tag, "_latency"}, k, exp_lat);
      popped = exp_q.pop_front();
      check({tag, "_lcm"}, lcm, popped);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt_snap;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_lcm", lcm, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);

      @(posedge clk); #1;
      gcd_done = 1'b1; gcd_in = 16'd5;
      repeat (2) begin @(posedge clk); #1; end
      gcd_done = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("idle_gcd_busy", {31'd0, busy}, 32'd0);
      check("idle_gcd_done_count", done_count, 0);

      run_op("t18_12", 16'd18, 16'd12, 16'd6, 2, 32'd36, 33, 1'b0);
      run_op("t1000_160", 16'd1000, 16'd160, 16'd40, 0, 32'd4000, 33, 1'b1);
      run_op("t3_15", 16'd3, 16'd15, 16'd3, 1, 32'd15, 33, 1'b0);
      run_op("tmax", 16'd65535, 16'd65534, 16'd1, 3, 32'hFFFD0002, 33, 1'b0);
      run_op("tzero", 16'd0, 16'd7, 16'd7, 1, 32'd0, 1, 1'b0);
      run_op("t18_12b", 16'd18, 16'd12, 16'd6, 0, 32'd36, 33, 1'b0);

      // Reset during DIV cycle 8 must discard the run silently.
      check("pre_reset_lcm", lcm, 32'd36);
      start = 1'b1; a = 16'd18; b = 16'd12;
      @(posedge clk); #1;
      start = 1'b0;
      gcd_done = 1'b1; gcd_in = 16'd6;
      @(posedge clk); #1;
      gcd_done = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt_snap = done_count;
      check("rst_lcm", lcm, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      repeat (40) begin @(posedge clk); #1; end
      check("rst_no_done", done_count, cnt_snap);

      run_op("t_after_rst", 16'd18, 16'd12, 16'd6, 1, 32'd36, 33, 1'b0);
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
